wb_regfile: RTL and testbench



---
 rtl/wb_regfile_if.sv | 40 ++++
 rtl/wb_regfile.sv | 80 ++++++++
 tb/tb_wb_regfile.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: bundle of the write-back and read-port signals of wb_regfile.
//   slave  modport : the register file (consumes write-back, drives read data)
//   master modport : the pipeline side (drives write-back and read requests)
// Signals:
//   wb_wreg/wb_wd/wb_wdata     GPR write enable, address, data from MEM/WB
//   wb_whilo/wb_hi/wb_lo       HI/LO write enable and data from MEM/WB
//   re1/raddr1/rdata1          read port 1 (ID)
//   re2/raddr2/rdata2          read port 2 (ID)
//   hi_o/lo_o                  current HI/LO (EX), bypassed
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wb_wreg;
  logic [ADDR_W-1:0] wb_wd;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_whilo;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport slave (
    input  wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2, hi_o, lo_o
  );

  modport master (
    output wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, hi_o, lo_o
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: write-back sink holding the architectural GPRs and HI/LO.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset; clears all state and forces outputs to 0
//   bus  : wb_regfile_if.slave -- write-back inputs, two GPR read ports, HI/LO outputs
// 32 GPRs (r0 hardwired to zero) with two combinational read ports and a HI/LO
// pair. Every read path bypasses the write-back presented in the same cycle.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  wb_regfile_if.slave   bus
);
  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [NREG];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // Storage update. Entry 0 is reset like the rest but never written, so it
  // stays zero and reads of it never expose an uninitialised value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (bus.wb_wreg && (bus.wb_wd != '0)) begin
        mem[bus.wb_wd] <= bus.wb_wdata;
      end
      if (bus.wb_whilo) begin
        hi_q <= bus.wb_hi;
        lo_q <= bus.wb_lo;
      end
    end
  end

  // Read port 1. Address 0 is checked before the bypass so a dropped write to
  // r0 can never leak through.
  always_comb begin
    bus.rdata1 = '0;
    if (!rst && bus.re1 && (bus.raddr1 != '0)) begin
      if (bus.wb_wreg && (bus.wb_wd == bus.raddr1)) begin
        bus.rdata1 = bus.wb_wdata;
      end else begin
        bus.rdata1 = mem[bus.raddr1];
      end
    end
  end

  // Read port 2, independent of port 1; both may bypass in the same cycle.
  always_comb begin
    bus.rdata2 = '0;
    if (!rst && bus.re2 && (bus.raddr2 != '0)) begin
      if (bus.wb_wreg && (bus.wb_wd == bus.raddr2)) begin
        bus.rdata2 = bus.wb_wdata;
      end else begin
        bus.rdata2 = mem[bus.raddr2];
      end
    end
  end

  // HI/LO read with bypass of the pending HI/LO write-back.
  always_comb begin
    bus.hi_o = '0;
    bus.lo_o = '0;
    if (!rst) begin
      if (bus.wb_whilo) begin
        bus.hi_o = bus.wb_hi;
        bus.lo_o = bus.wb_lo;
      end else begin
        bus.hi_o = hi_q;
        bus.lo_o = lo_q;
      end
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: self-checking bench for wb_regfile.
// A table of hand-computed vectors covers write/read, bypass, r0 and HI/LO;
// hand sequences cover reset; a random sweep is checked against a reference
// array model. Every expectation goes through a scoreboard queue.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        expQ[$];
  int          vecCount = 0;
  int          missCount = 0;
  logic [31:0] mdl [32];
  logic [31:0] mdlHi;
  logic [31:0] mdlLo;
  vec_t        vecs [15];

  // Drive one cycle of inputs and queue the expected outputs.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    bus.wb_wreg  = v.wreg;
    bus.wb_wd    = v.wd;
    bus.wb_wdata = v.wdata;
    bus.wb_whilo = v.whilo;
    bus.wb_hi    = v.hi;
    bus.wb_lo    = v.lo;
    bus.re1      = v.re1;
    bus.raddr1   = v.ra1;
    bus.re2      = v.re2;
    bus.raddr2   = v.ra2;
    e.r1 = v.e1;
    e.r2 = v.e2;
    e.hi = v.ehi;
    e.lo = v.elo;
    expQ.push_back(e);
  endtask

  task automatic cmpField(input string name, input string fld,
                          input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      missCount++;
      $display("[TB] FAIL %s %s got %h want %h", name, fld, got, want);
    end
  endtask

  // Pop the oldest expectation and compare against the settled DUT outputs.
  task automatic checkOutput(input string name);
    exp_t e;
    vecCount++;
    if (expQ.size() == 0) begin
      missCount++;
      $display("[TB] FAIL %s scoreboard empty got 0 entries want 1", name);
    end else begin
      e = expQ.pop_front();
      cmpField(name, "rdata1", bus.rdata1, e.r1);
      cmpField(name, "rdata2", bus.rdata2, e.r2);
      cmpField(name, "hi_o",   bus.hi_o,   e.hi);
      cmpField(name, "lo_o",   bus.lo_o,   e.lo);
    end
  endtask

  // Reference read of one GPR port under the current inputs.
  function automatic logic [31:0] modelRead(input vec_t v, input logic re,
                                            input logic [4:0] ra);
    if (rst || !re || ra == 5'd0) return 32'h0;
    if (v.wreg && v.wd == ra) return v.wdata;
    return mdl[ra];
  endfunction

  function automatic vec_t fillExpected(input vec_t v);
    vec_t r = v;
    r.e1  = modelRead(v, v.re1, v.ra1);
    r.e2  = modelRead(v, v.re2, v.ra2);
    r.ehi = rst ? 32'h0 : (v.whilo ? v.hi : mdlHi);
    r.elo = rst ? 32'h0 : (v.whilo ? v.lo : mdlLo);
    return r;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    mdlHi = 32'h0;
    mdlLo = 32'h0;
  endtask

  // Advance to the next posedge and apply the same write to the model.
  task automatic stepClock();
    @(posedge clk);
    if (!rst) begin
      if (bus.wb_wreg && bus.wb_wd != 5'd0) mdl[bus.wb_wd] = bus.wb_wdata;
      if (bus.wb_whilo) begin
        mdlHi = bus.wb_hi;
        mdlLo = bus.wb_lo;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout got no finish want finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    clearModel();

    // Reset state: outputs are zero even with a bypassable write presented.
    applyStimulus('{1'b1, 5'd7, 32'hCAFEF00D, 1'b1, 32'h1, 32'h2,
                    1'b1, 5'd7, 1'b1, 5'd7, 32'h0, 32'h0, 32'h0, 32'h0});
    #1 checkOutput("reset_state");
    @(negedge clk);
    applyStimulus('0);
    rst = 1'b0;
    void'(expQ.pop_back());
    stepClock();

    //            wreg wd    wdata         whilo hi            lo            re1 ra1   re2 ra2   e1            e2            ehi           elo
    vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 5'd5, 1'b1, 5'd5, 32'h0,        32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 32'h0,        32'h0,        1'b0, 5'd7, 1'b1, 5'd7, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 5'd7, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 5'd7, 1'b0, 5'd7, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
    vecs[3]  = '{1'b1, 5'd3, 32'h11111111, 1'b0, 32'h0,        32'h0,        1'b1, 5'd3, 1'b1, 5'd3, 32'h11111111, 32'h11111111, 32'h0,        32'h0};
    vecs[4]  = '{1'b1, 5'd3, 32'h22222222, 1'b0, 32'h0,        32'h0,        1'b1, 5'd3, 1'b1, 5'd3, 32'h22222222, 32'h22222222, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 5'd3, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 5'd3, 1'b1, 5'd3, 32'h22222222, 32'h22222222, 32'h0,        32'h0};
    vecs[6]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h0,        1'b1, 5'd0, 1'b1, 5'd3, 32'h0,        32'h22222222, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 5'd0, 1'b1, 5'd7, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 32'h00000012, 32'h34000000, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,        32'h00000012, 32'h34000000};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 32'hAAAAAAAA, 32'hBBBBBBBB, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,        32'h00000012, 32'h34000000};
    vecs[10] = '{1'b1, 5'd9, 32'h00000001, 1'b0, 32'h0,        32'h0,        1'b1, 5'd9, 1'b0, 5'd9, 32'h00000001, 32'h0,        32'h00000012, 32'h34000000};
    vecs[11] = '{1'b1, 5'd9, 32'h00000002, 1'b0, 32'h0,        32'h0,        1'b1, 5'd9, 1'b1, 5'd9, 32'h00000002, 32'h00000002, 32'h00000012, 32'h34000000};
    vecs[12] = '{1'b0, 5'd9, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 5'd9, 1'b1, 5'd31, 32'h00000002, 32'h0,       32'h00000012, 32'h34000000};
    vecs[13] = '{1'b1, 5'd31, 32'h80000001, 1'b1, 32'h5,       32'h6,        1'b1, 5'd31, 1'b1, 5'd9, 32'h80000001, 32'h00000002, 32'h5,        32'h6};
    vecs[14] = '{1'b0, 5'd31, 32'h0,       1'b0, 32'hFFFF0000, 32'h0000FFFF, 1'b1, 5'd31, 1'b1, 5'd3, 32'h80000001, 32'h22222222, 32'h5,        32'h6};

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1 checkOutput($sformatf("vec%0d", i));
      stepClock();
    end

    // Asynchronous reset mid-cycle while a bypassable write is presented.
    @(negedge clk);
    v = '{1'b1, 5'd7, 32'h12345678, 1'b1, 32'h11, 32'h22, 1'b1, 5'd7, 1'b1, 5'd3,
          32'h0, 32'h0, 32'h0, 32'h0};
    applyStimulus(fillExpected(v));
    #1 checkOutput("pre_reset_bypass");
    #1 rst = 1'b1;
    clearModel();
    applyStimulus(fillExpected(v));
    #1 checkOutput("async_reset");
    stepClock();

    // A write presented as reset deasserts lands at the following posedge.
    @(negedge clk);
    rst = 1'b0;
    v = '{1'b1, 5'd4, 32'h44444444, 1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd7,
          32'h0, 32'h0, 32'h0, 32'h0};
    applyStimulus(fillExpected(v));
    #1 checkOutput("post_reset_r5");
    stepClock();
    @(negedge clk);
    v = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd3,
          32'h44444444, 32'h0, 32'h0, 32'h0};
    applyStimulus(v);
    #1 checkOutput("write_at_deassert");
    stepClock();

    // Random sweep against the reference model; addresses biased low so
    // back-to-back writes and bypasses to the same register are frequent.
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      v = '0;
      v.wreg  = ($urandom_range(0, 3) != 0);
      v.wd    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      v.wdata = $urandom;
      v.whilo = ($urandom_range(0, 3) == 0);
      v.hi    = $urandom;
      v.lo    = $urandom;
      v.re1   = ($urandom_range(0, 7) != 0);
      v.ra1   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      v.re2   = ($urandom_range(0, 7) != 0);
      v.ra2   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      applyStimulus(fillExpected(v));
      #1 checkOutput("random");
      stepClock();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
